// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART link constants and the receiver state type. The bit period
//   matches the uart_tcvr transmitter on the other end of the link.
//   No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BIT_CYCLES  = 55;                   // clocks per bit
    localparam int UART_HALF_CYCLES = UART_BIT_CYCLES / 2;  // start edge -> mid-bit

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial input. Both flops
//   reset to 1 so a reset never looks like a start bit.
// Ports
//   clock    in   system clock
//   reset    in   asynchronous, active-high
//   rx_async in   raw serial line from the pin
//   rx_s     out  synchronized serial line (second flop)
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_async,
    output logic rx_s
);

    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;

    always_comb begin
        rx_meta_d = rx_async;
        rx_s_d    = rx_meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    assign rx_s = rx_s_q;

endmodule

// File: rtl/uart_rcvr.sv
// ---------------------------------------------------------------------------
// uart_rcvr
//   8N1 UART receiver. Synchronizes the serial line, qualifies the start bit
//   at mid-bit, samples eight data bits LSB first at mid-bit, checks the stop
//   bit and presents the byte with a one-cycle strobe.
// Ports
//   clock           in   system clock
//   reset           in   asynchronous, active-high
//   uart_rx         in   serial input, idle high, asynchronous to clock
//   uart_data       out  last good byte, held until the next good byte
//   uart_data_valid out  1-cycle strobe, uart_data just updated
//   framing_error   out  1-cycle strobe, stop bit sampled low
//   rx_busy         out  high whenever the FSM is not IDLE
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | line idle, waiting for a low level
//   START | timing half a bit to re-check the start bit at mid-bit
//   DATA  | sampling data bits 0..7 once per bit period
//   STOP  | sampling the stop bit; high -> deliver byte, low -> error
//   BREAK | stop bit was low; wait for the line to go high again
// ---------------------------------------------------------------------------
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES  = UART_BIT_CYCLES,
    parameter int HALF_CYCLES = UART_HALF_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    logic rx_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .rx_async (uart_rx),
        .rx_s     (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Line back high at mid-start means a glitch, not a frame.
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop lets a start bit that follows
                // the stop bit with no idle gap be caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must not look like a fresh start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign uart_data       = data_q;
    assign uart_data_valid = valid_q;
    assign framing_error   = ferr_q;
    assign rx_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rcvr.sv
module tb_uart_rcvr;

    logic       clock = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic       framing_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    int         fe_cnt      = 0;
    int         overlap_cnt = 0;

    always #5 clock = ~clock;

    uart_rcvr #(
        .BIT_CYCLES  (55),
        .HALF_CYCLES (27)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .uart_rx         (uart_rx),
        .uart_data       (uart_data),
        .uart_data_valid (uart_data_valid),
        .framing_error   (framing_error),
        .rx_busy         (rx_busy)
    );

    // Strobe monitor, sampled mid-cycle; a strobe wider than one cycle
    // shows up as extra entries or counts.
    always @(negedge clock) begin
        if (uart_data_valid) rx_q.push_back(uart_data);
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (uart_data_valid && framing_error) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int bc);
        uart_rx = b;
        repeat (bc) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
        send_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) send_bit(d[i], bc);
        send_bit(stop, bc);
    endtask

    initial begin
        int         base;
        int         fe0;
        int         lat;
        int         busy_n;
        int         rates[2];
        logic [7:0] exp_b[16];

        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_data",  32'(uart_data),       32'h00);
        check("rst_valid", 32'(uart_data_valid), 32'h0);
        check("rst_ferr",  32'(framing_error),   32'h0);
        check("rst_busy",  32'(rx_busy),         32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 1: single 0xA5 frame, latency from falling start edge to strobe
        base = rx_q.size();
        fe0  = fe_cnt;
        lat  = 0;
        fork
            send_frame(8'hA5, 1'b1, 55);
            begin
                for (int n = 1; n <= 2000; n++) begin
                    @(posedge clock);
                    #1;
                    if (uart_data_valid) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        uart_rx = 1'b1;
        repeat (10) @(negedge clock);
        check("t1_latency", 32'(lat), 32'd525);
        check("t1_count",   32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) check("t1_byte", 32'(rx_q[base]), 32'hA5);
        check("t1_data",    32'(uart_data), 32'hA5);
        check("t1_ferr",    32'(fe_cnt - fe0), 32'd0);

        // 2: 10-cycle low glitch on an idle line
        base   = rx_q.size();
        fe0    = fe_cnt;
        busy_n = 0;
        uart_rx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rx_busy) busy_n++;
            if (i == 9) uart_rx = 1'b1;
        end
        check("t2_busy_cycles", 32'(busy_n), 32'd27);
        check("t2_busy_end",    32'(rx_busy), 32'h0);
        check("t2_count",       32'(rx_q.size() - base), 32'd0);
        check("t2_data",        32'(uart_data), 32'hA5);
        check("t2_ferr",        32'(fe_cnt - fe0), 32'd0);

        // 3: 0x3C with a low stop bit, then line held low
        base = rx_q.size();
        fe0  = fe_cnt;
        send_frame(8'h3C, 1'b0, 55);
        uart_rx = 1'b0;
        repeat (200) @(negedge clock);
        check("t3_ferr",     32'(fe_cnt - fe0), 32'd1);
        check("t3_count",    32'(rx_q.size() - base), 32'd0);
        check("t3_data",     32'(uart_data), 32'hA5);
        check("t3_busy_low", 32'(rx_busy), 32'h1);
        uart_rx = 1'b1;
        repeat (5) @(negedge clock);
        check("t3_busy_rel", 32'(rx_busy), 32'h0);
        repeat (20) @(negedge clock);
        check("t3_no_retrig", 32'(rx_q.size() - base), 32'd0);

        // 4: back-to-back frames with no idle gap
        base = rx_q.size();
        fe0  = fe_cnt;
        send_frame(8'h00, 1'b1, 55);
        send_frame(8'hFF, 1'b1, 55);
        send_frame(8'h55, 1'b1, 55);
        uart_rx = 1'b1;
        repeat (60) @(negedge clock);
        check("t4_count", 32'(rx_q.size() - base), 32'd3);
        if (rx_q.size() >= base + 3) begin
            check("t4_b0", 32'(rx_q[base]),     32'h00);
            check("t4_b1", 32'(rx_q[base + 1]), 32'hFF);
            check("t4_b2", 32'(rx_q[base + 2]), 32'h55);
        end
        check("t4_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("t4_data", 32'(uart_data), 32'h55);

        // 5: reset in the middle of 0x81's data bits, then 0x7E
        base = rx_q.size();
        send_bit(1'b0, 55);
        send_bit(1'b1, 55);
        send_bit(1'b0, 55);
        send_bit(1'b0, 55);
        repeat (20) @(negedge clock);
        check("t5_busy_pre", 32'(rx_busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_data",  32'(uart_data),       32'h00);
        check("t5_rst_busy",  32'(rx_busy),         32'h0);
        check("t5_rst_valid", 32'(uart_data_valid), 32'h0);
        check("t5_rst_ferr",  32'(framing_error),   32'h0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        send_frame(8'h7E, 1'b1, 55);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        check("t5_count", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) check("t5_byte", 32'(rx_q[base]), 32'h7E);
        check("t5_data", 32'(uart_data), 32'h7E);

        // 6: transmitter running at -3.6% and +3.6% bit period
        rates[0] = 53;
        rates[1] = 57;
        for (int r = 0; r < 2; r++) begin
            base = rx_q.size();
            fe0  = fe_cnt;
            for (int k = 0; k < 16; k++) begin
                exp_b[k] = 8'($urandom_range(0, 255));
                send_frame(exp_b[k], 1'b1, rates[r]);
            end
            uart_rx = 1'b1;
            repeat (80) @(negedge clock);
            check($sformatf("t6_count_%0d", rates[r]), 32'(rx_q.size() - base), 32'd16);
            check($sformatf("t6_ferr_%0d", rates[r]),  32'(fe_cnt - fe0), 32'd0);
            for (int k = 0; k < 16; k++) begin
                if (rx_q.size() > base + k)
                    check($sformatf("t6_b%0d_%0d", k, rates[r]), 32'(rx_q[base + k]), 32'(exp_b[k]));
            end
        end

        check("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
